lsu_sequencer: RTL and testbench

Load/store sequencer between the execute stage and the single-ported data memory. It accepts one RV32I load or store (`lb/lh/lw/lbu/lhu/sb/sh/sw`) per request handshake and drives word-aligned memory beats with byte-lane masks. Accesses that cross a word boundary are split into two beats. Load data is merged, shifted and extended before being returned on a response handshake.

---
 rtl/lsu_sequencer_if.sv | 37 +++
 rtl/lsu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_sequencer_if.sv
// Bundle for the sequencer's request/response handshake and its memory beat port.
// The slave modport is the sequencer's view; master is the execute stage plus memory.
interface lsu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one RV32I load/store into one or two word-aligned
// memory beats and returns the merged, extended load result.
//
// state | meaning
// IDLE  | waiting for a request (req_ready = 1)
// ACC0  | first (or only) memory beat outstanding
// ACC1  | second beat of a word-crossing access outstanding
// RESP  | response held until resp_ready
module lsu_sequencer #(
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst_n,
  lsu_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMR_LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state;
  logic [CW-1:0] tmr;
  logic          store_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          split_q;
  logic [3:0]    mask1_q;
  logic [31:0]   wdata1_q;
  logic [31:0]   beat0_q;

  logic [1:0]  off;
  logic        legal;
  logic [3:0]  base_mask;
  logic [7:0]  lanes;
  logic [63:0] wvec;
  logic [55:0] rvec;
  logic [31:0] rwin;
  logic        in_acc;
  logic        acked;
  logic        expired;
  logic        go_beat1;

  assign bus.req_ready = (state == IDLE);

  assign off = bus.req_addr[1:0];

  always_comb begin
    legal = 1'b0;
    if (bus.req_store) begin
      legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010);
    end else begin
      legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
              (bus.req_funct3 == 3'b101);
    end
  end

  always_comb begin
    base_mask = 4'b0000;
    case (bus.req_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  end

  // Upper nibble of the lane vector is the beat-1 mask; nonzero means a split.
  assign lanes = {4'b0000, base_mask} << off;
  assign wvec  = {32'b0, bus.req_wdata} << {off, 3'b000};

  // Byte 7 of the merged pair can never be selected, so only 7 bytes are kept.
  assign rvec = (state == ACC1) ? {bus.mem_rdata[23:0], beat0_q}
                                : {24'b0, bus.mem_rdata};

  always_comb begin
    rwin = rvec[31:0];
    case (off_q)
      2'd0: rwin = rvec[31:0];
      2'd1: rwin = rvec[39:8];
      2'd2: rwin = rvec[47:16];
      2'd3: rwin = rvec[55:24];
      default: rwin = rvec[31:0];
    endcase
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  extend = {{24{v[7]}}, v[7:0]};
      3'b001:  extend = {{16{v[15]}}, v[15:0]};
      3'b100:  extend = {24'b0, v[7:0]};
      3'b101:  extend = {16'b0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  assign in_acc   = (state == ACC0) || (state == ACC1);
  assign acked    = in_acc && bus.mem_req && bus.mem_ack;
  assign expired  = in_acc && !acked && (TIMEOUT != 0) && (tmr == '0);
  assign go_beat1 = acked && (state == ACC0) && split_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tmr            <= '0;
      store_q        <= 1'b0;
      f3_q           <= 3'b000;
      off_q          <= 2'b00;
      split_q        <= 1'b0;
      mask1_q        <= 4'b0000;
      wdata1_q       <= 32'b0;
      beat0_q        <= 32'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'b0;
      bus.mem_wdata  <= 32'b0;
      bus.mem_mask   <= 4'b0000;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'b0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            store_q  <= bus.req_store;
            f3_q     <= bus.req_funct3;
            off_q    <= off;
            split_q  <= |lanes[7:4];
            mask1_q  <= lanes[7:4];
            wdata1_q <= wvec[63:32];
            tmr      <= TMR_LOAD;
            if (!legal) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'b0;
            end else begin
              state         <= ACC0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_store;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_mask  <= lanes[3:0];
              bus.mem_wdata <= wvec[31:0];
            end
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
          end
        end
        default: begin
          if (acked && (state == ACC0)) beat0_q <= bus.mem_rdata;
          if (go_beat1) begin
            // mem_req stays high; the address wraps naturally at 2^32.
            state         <= ACC1;
            tmr           <= TMR_LOAD;
            bus.mem_addr  <= bus.mem_addr + 32'd4;
            bus.mem_mask  <= mask1_q;
            bus.mem_wdata <= wdata1_q;
          end else if (acked || expired) begin
            state          <= RESP;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_mask   <= 4'b0000;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= expired;
            bus.resp_rdata <= (expired || store_q) ? 32'b0 : extend(f3_q, rwin);
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: a table of single accesses with hand-computed
// beats and results, plus sequences for timeout, back-pressure, throughput and reset.
module tb_lsu_sequencer;

  logic clk;
  logic rst_n;
  logic ack_en;

  lsu_sequencer_if bus ();

  lsu_sequencer #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0200: mem_word = 32'h1122_3344;
      32'h0000_0204: mem_word = 32'h5566_7788;
      default:       mem_word = 32'h0000_0000;
    endcase
  endfunction

  assign bus.mem_ack   = ack_en && bus.mem_req;
  assign bus.mem_rdata = mem_word(bus.mem_addr);

  int          nb;
  logic [31:0] b_addr  [4];
  logic [3:0]  b_mask  [4];
  logic [31:0] b_wdata [4];
  logic        b_we    [4];

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack && nb < 4) begin
      b_addr[nb]  = bus.mem_addr;
      b_mask[nb]  = bus.mem_mask;
      b_wdata[nb] = bus.mem_wdata;
      b_we[nb]    = bus.mem_we;
      nb = nb + 1;
    end
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] w1;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic wait_ready(input string nm);
    for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    nb             = 0;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input int i);
    string nm;
    int    lat;
    nm = $sformatf("v%0d", i);
    wait_ready(nm);
    drive_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
    wait_resp(lat);
    chk({nm, " latency"}, 32'(lat), (vecs[i].beats == 0) ? 32'd1 : 32'(1 + vecs[i].beats));
    chk({nm, " resp_rdata"}, bus.resp_rdata, vecs[i].rd);
    chk({nm, " resp_err"}, 32'(bus.resp_err), 32'(vecs[i].err));
    chk({nm, " beats"}, 32'(nb), 32'(vecs[i].beats));
    for (int b = 0; b < vecs[i].beats && b < nb; b++) begin
      chk($sformatf("%s b%0d addr", nm, b), b_addr[b], (b == 0) ? vecs[i].a0 : vecs[i].a1);
      chk($sformatf("%s b%0d mask", nm, b), 32'(b_mask[b]), 32'((b == 0) ? vecs[i].m0 : vecs[i].m1));
      chk($sformatf("%s b%0d wdata", nm, b), b_wdata[b], (b == 0) ? vecs[i].w0 : vecs[i].w1);
      chk($sformatf("%s b%0d we", nm, b), 32'(b_we[b]), 32'(vecs[i].st));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hi;
    int acc;
    int seen;

    n_cmp = 0;
    n_bad = 0;
    nb    = 0;

    //           st    f3      addr          wdata         bt a0            m0     w0            a1            m1     w1            rd            err
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0000_0100, 4'h8, 32'hA500_0000, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 3'b001, 32'h0000_0203, 32'h0,         2, 32'h0000_0200, 4'h8, 32'h0,         32'h0000_0204, 4'h1, 32'h0,        32'hFFFF_8811, 1'b0};
    vecs[3]  = '{1'b0, 3'b101, 32'h0000_0203, 32'h0,         2, 32'h0000_0200, 4'h8, 32'h0,         32'h0000_0204, 4'h1, 32'h0,        32'h0000_8811, 1'b0};
    vecs[4]  = '{1'b0, 3'b000, 32'h0000_0202, 32'h0,         1, 32'h0000_0200, 4'h4, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0000_0022, 1'b0};
    vecs[5]  = '{1'b1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 2, 32'h0000_0100, 4'hC, 32'hCCDD_0000, 32'h0000_0104, 4'h3, 32'h0000_AABB, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1234_5678, 2, 32'hFFFF_FFFC, 4'hC, 32'h5678_0000, 32'h0000_0000, 4'h3, 32'h0000_1234, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         1, 32'h0000_0200, 4'hF, 32'h0,         32'h0,        4'h0, 32'h0,        32'h1122_3344, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_0201, 32'h0,         2, 32'h0000_0200, 4'hE, 32'h0,         32'h0000_0204, 4'h1, 32'h0,        32'h8811_2233, 1'b0};
    vecs[9]  = '{1'b0, 3'b000, 32'h0000_0204, 32'h0,         1, 32'h0000_0204, 4'h1, 32'h0,         32'h0,        4'h0, 32'h0,        32'hFFFF_FF88, 1'b0};
    vecs[10] = '{1'b0, 3'b101, 32'h0000_0206, 32'h0,         1, 32'h0000_0204, 4'hC, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0000_5566, 1'b0};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0101, 32'hFFFF_1234, 1, 32'h0000_0100, 4'h6, 32'hFF12_3400, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 2, 32'h0000_0100, 4'h8, 32'hEF00_0000, 32'h0000_0104, 4'h1, 32'h0000_00BE, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         0, 32'h0,        4'h0, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 0, 32'h0,        4'h0, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[15] = '{1'b0, 3'b110, 32'h0000_0200, 32'h0,         0, 32'h0,        4'h0, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[16] = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,         1, 32'h0000_0200, 4'h8, 32'h0,         32'h0,        4'h0, 32'h0,        32'h0000_0011, 1'b0};

    rst_n          = 1'b1;
    ack_en         = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst mem_mask", 32'(bus.mem_mask), 32'd0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Timeout: no ack ever; mem_req must be high for exactly TIMEOUT cycles.
    wait_ready("tmo");
    ack_en = 1'b0;
    drive_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    hi = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1;
        break;
      end
      if (bus.mem_req) hi = hi + 1;
    end
    chk("tmo resp_valid", 32'(seen), 32'd1);
    chk("tmo mem_req cycles", 32'(hi), 32'd4);
    chk("tmo mem_req low", 32'(bus.mem_req), 32'd0);
    chk("tmo resp_err", 32'(bus.resp_err), 32'd1);
    chk("tmo resp_rdata", bus.resp_rdata, 32'd0);
    ack_en = 1'b1;

    // Back-pressure: response must hold steady while resp_ready is low.
    wait_ready("bp");
    bus.resp_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h0000_0201, 32'h0);
    wait_resp(lat);
    chk("bp latency", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d resp_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("bp%0d resp_rdata", k), bus.resp_rdata, 32'h8811_2233);
      chk($sformatf("bp%0d req_ready", k), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp released", 32'(bus.resp_valid), 32'd0);

    // Throughput: continuous aligned loads accept once every 3 cycles.
    wait_ready("tp");
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0200;
    acc = 0;
    repeat (12) begin
      @(posedge clk);
      if (bus.req_valid && bus.req_ready) acc = acc + 1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("tp accepts", 32'(acc), 32'd4);

    // Reset during the second beat abandons the access.
    wait_ready("rst");
    drive_req(1'b1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD);
    @(negedge clk);
    @(negedge clk);
    chk("rst acc1 addr", bus.mem_addr, 32'h0000_0104);
    chk("rst acc1 mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst async resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) seen = seen + 1;
    end
    chk("rst no response", 32'(seen), 32'd0);
    chk("rst after req_ready", 32'(bus.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
